// File: rtl/execute_muldiv_ctrl.sv
// HI/LO multiply/divide controller beside the execute ALU: sequences multi-cycle
// MULT/DIV family ops, owns the architectural HI/LO registers and drives busy.
module execute_muldiv_ctrl #(
    parameter int MUL_CYCLES = 3
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [3:0]  in_op,
    input  logic [31:0] in_vs,
    input  logic [31:0] in_vt,
    input  logic        flush,
    output logic        busy,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic        done,
    output logic [31:0] result,
    output logic [1:0]  fsm_state
);
    // Handshake: an op is taken at a clk edge where in_valid && in_ready && !flush
    // and in_op is a known code; in_ready is high only in IDLE, one op in flight.
    localparam logic [3:0] OP_MULT  = 4'd1;
    localparam logic [3:0] OP_MULTU = 4'd2;
    localparam logic [3:0] OP_DIV   = 4'd3;
    localparam logic [3:0] OP_DIVU  = 4'd4;
    localparam logic [3:0] OP_MTHI  = 4'd5;
    localparam logic [3:0] OP_MTLO  = 4'd6;
    localparam logic [3:0] OP_MADD  = 4'd7;
    localparam logic [3:0] OP_MADDU = 4'd8;
    localparam logic [3:0] OP_MSUB  = 4'd9;
    localparam logic [3:0] OP_MSUBU = 4'd10;
    localparam logic [3:0] OP_MUL   = 4'd11;

    localparam logic [4:0] MUL_LAST = 5'(MUL_CYCLES - 1);
    localparam logic [4:0] DIV_LAST = 5'd31;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DIV  = 2'd2
    } state_t;

    state_t      state, state_next;
    logic [3:0]  op_q;
    logic [31:0] vs_q;
    logic [31:0] vt_q;
    logic [31:0] rem_q;
    logic        q_neg;
    logic        r_neg;
    logic [4:0]  cnt;

    logic        in_is_mul, in_is_div, in_is_mt;
    logic        accept, fin_mul, fin_div;
    logic        mul_signed;
    logic [63:0] mul_a, mul_b, prod, hilo_next;
    logic [32:0] shifted, diff;
    logic        fits;
    logic [31:0] rem_step, quo_step, quo_final, rem_final;

    assign in_is_mul = in_op inside {OP_MULT, OP_MULTU, OP_MADD, OP_MADDU,
                                     OP_MSUB, OP_MSUBU, OP_MUL};
    assign in_is_div = in_op inside {OP_DIV, OP_DIVU};
    assign in_is_mt  = in_op inside {OP_MTHI, OP_MTLO};

    assign in_ready  = (state == IDLE);
    assign busy      = (state != IDLE);
    assign fsm_state = state;

    always_comb begin
        state_next = state;
        accept     = 1'b0;
        fin_mul    = 1'b0;
        fin_div    = 1'b0;
        if (flush) begin
            state_next = IDLE;
        end else begin
            case (state)
                IDLE: begin
                    accept = in_valid && (in_is_mul || in_is_div || in_is_mt);
                    if (accept && in_is_mul)      state_next = MUL;
                    else if (accept && in_is_div) state_next = DIV;
                end
                MUL: if (cnt == 5'd0) begin
                    state_next = IDLE;
                    fin_mul    = 1'b1;
                end
                DIV: if (cnt == 5'd0) begin
                    state_next = IDLE;
                    fin_div    = 1'b1;
                end
                default: state_next = IDLE;
            endcase
        end
    end

    // Operands are sign/zero extended to 64 bits so one unsigned multiply serves both.
    assign mul_signed = op_q inside {OP_MULT, OP_MADD, OP_MSUB, OP_MUL};
    assign mul_a = {{32{mul_signed & vs_q[31]}}, vs_q};
    assign mul_b = {{32{mul_signed & vt_q[31]}}, vt_q};
    assign prod  = mul_a * mul_b;

    always_comb begin
        hilo_next = prod;
        case (op_q)
            OP_MADD, OP_MADDU: hilo_next = {hi, lo} + prod;
            OP_MSUB, OP_MSUBU: hilo_next = {hi, lo} - prod;
            default:           hilo_next = prod;
        endcase
    end

    // Restoring divide step: vs_q shifts the dividend out and quotient bits in.
    assign shifted   = {rem_q, vs_q[31]};
    assign diff      = shifted - {1'b0, vt_q};
    assign fits      = ~diff[32];
    assign rem_step  = fits ? diff[31:0] : shifted[31:0];
    assign quo_step  = {vs_q[30:0], fits};
    assign quo_final = q_neg ? -quo_step : quo_step;
    assign rem_final = r_neg ? -rem_step : rem_step;

    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= IDLE;
            hi     <= 32'd0;
            lo     <= 32'd0;
            done   <= 1'b0;
            result <= 32'd0;
            cnt    <= 5'd0;
            op_q   <= 4'd0;
            vs_q   <= 32'd0;
            vt_q   <= 32'd0;
            rem_q  <= 32'd0;
            q_neg  <= 1'b0;
            r_neg  <= 1'b0;
        end else begin
            state <= state_next;
            done  <= 1'b0;
            if (accept) begin
                op_q  <= in_op;
                vs_q  <= (in_op == OP_DIV && in_vs[31]) ? -in_vs : in_vs;
                vt_q  <= (in_op == OP_DIV && in_vt[31]) ? -in_vt : in_vt;
                rem_q <= 32'd0;
                q_neg <= (in_op == OP_DIV) && (in_vs[31] ^ in_vt[31]);
                r_neg <= (in_op == OP_DIV) && in_vs[31];
                cnt   <= in_is_div ? DIV_LAST : MUL_LAST;
                if (in_op == OP_MTHI) begin
                    hi   <= in_vs;
                    done <= 1'b1;
                end
                if (in_op == OP_MTLO) begin
                    lo   <= in_vs;
                    done <= 1'b1;
                end
            end
            if (state != IDLE && cnt != 5'd0) cnt <= cnt - 5'd1;
            if (state == DIV) begin
                vs_q  <= quo_step;
                rem_q <= rem_step;
            end
            if (fin_mul) begin
                done <= 1'b1;
                if (op_q == OP_MUL) begin
                    result <= prod[31:0];
                end else begin
                    hi <= hilo_next[63:32];
                    lo <= hilo_next[31:0];
                end
            end
            // A zero divisor still runs the full latency but leaves HI/LO untouched.
            if (fin_div) begin
                done <= 1'b1;
                if (vt_q != 32'd0) begin
                    lo <= quo_final;
                    hi <= rem_final;
                end
            end
        end
    end

endmodule

// File: tb/tb_execute_muldiv_ctrl.sv
// Bench for execute_muldiv_ctrl: directed scenarios plus random ops, checked by a
// scoreboard fed from an arithmetic HI/LO reference model.
module tb_execute_muldiv_ctrl;
  localparam int MUL_CYCLES = 3;
  localparam int W = 137;  // {chk_result, latency[7:0], done_cycle[31:0], hi, lo, result}

  localparam logic [3:0] OP_MULT  = 4'd1;
  localparam logic [3:0] OP_MULTU = 4'd2;
  localparam logic [3:0] OP_DIV   = 4'd3;
  localparam logic [3:0] OP_DIVU  = 4'd4;
  localparam logic [3:0] OP_MTHI  = 4'd5;
  localparam logic [3:0] OP_MTLO  = 4'd6;
  localparam logic [3:0] OP_MADD  = 4'd7;
  localparam logic [3:0] OP_MADDU = 4'd8;
  localparam logic [3:0] OP_MSUB  = 4'd9;
  localparam logic [3:0] OP_MSUBU = 4'd10;
  localparam logic [3:0] OP_MUL   = 4'd11;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [3:0]  in_op = 4'd0;
  logic [31:0] in_vs = 32'd0;
  logic [31:0] in_vt = 32'd0;
  logic        flush = 1'b0;
  logic        busy;
  logic [31:0] hi, lo, result;
  logic        done;
  logic [1:0]  fsm_state;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int busy_run = 0;
  logic [W-1:0] exp_q[$];
  logic [W-1:0] mon_e;
  logic [31:0] m_hi = 32'd0;
  logic [31:0] m_lo = 32'd0;

  execute_muldiv_ctrl #(.MUL_CYCLES(MUL_CYCLES)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_op(in_op), .in_vs(in_vs), .in_vt(in_vt), .flush(flush), .busy(busy),
    .hi(hi), .lo(lo), .done(done), .result(result), .fsm_state(fsm_state)
  );

  // clock / reset
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #600000;
    $display("FAIL watchdog: simulation did not finish in time (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [31:0] rnd32();
    case ($urandom_range(0, 5))
      0: return 32'd0;
      1: return 32'd1;
      2: return 32'hFFFF_FFFF;
      3: return 32'h8000_0000;
      default: return $urandom;
    endcase
  endfunction

  // reference model: HI/LO as a 64-bit value updated with plain arithmetic
  task automatic model_push(input logic [3:0] op, input logic [31:0] vs, input logic [31:0] vt,
                            input int acc);
    logic [63:0] p, hl;
    longint a, b, q, r;
    int lat;
    logic cr;
    logic [31:0] res;
    bit push;
    hl = {m_hi, m_lo};
    res = 32'd0;
    cr = 1'b0;
    push = 1'b1;
    lat = 0;
    if (op == OP_MULT || op == OP_MADD || op == OP_MSUB || op == OP_MUL)
      p = longint'($signed(vs)) * longint'($signed(vt));
    else
      p = {32'd0, vs} * {32'd0, vt};
    case (op)
      OP_MULT, OP_MULTU: begin hl = p; lat = MUL_CYCLES; end
      OP_MADD, OP_MADDU: begin hl = hl + p; lat = MUL_CYCLES; end
      OP_MSUB, OP_MSUBU: begin hl = hl - p; lat = MUL_CYCLES; end
      OP_MUL: begin res = p[31:0]; cr = 1'b1; lat = MUL_CYCLES; end
      OP_DIV: begin
        lat = 32;
        if (vt != 32'd0) begin
          a = longint'($signed(vs));
          b = longint'($signed(vt));
          q = a / b;
          r = a % b;
          hl = {r[31:0], q[31:0]};
        end
      end
      OP_DIVU: begin
        lat = 32;
        if (vt != 32'd0) hl = {vs % vt, vs / vt};
      end
      OP_MTHI: hl[63:32] = vs;
      OP_MTLO: hl[31:0] = vs;
      default: push = 1'b0;
    endcase
    m_hi = hl[63:32];
    m_lo = hl[31:0];
    if (push) exp_q.push_back({cr, 8'(lat), 32'(acc + lat), m_hi, m_lo, res});
  endtask

  // driver: holds in_valid until accepted; cancel=1 means the op will be aborted
  task automatic issue(input logic [3:0] op, input logic [31:0] vs, input logic [31:0] vt,
                       input bit cancel, output int acc, output int held);
    @(negedge clk);
    in_valid = 1'b1;
    in_op = op;
    in_vs = vs;
    in_vt = vt;
    held = 0;
    while (!in_ready && held < 100) begin
      @(negedge clk);
      held++;
    end
    if (!in_ready) begin
      chk("ready_timeout", 32'(in_ready), 32'd1);
      in_valid = 1'b0;
      acc = cyc;
      return;
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_op = 4'd0;
    acc = cyc;
    if (!cancel) model_push(op, vs, vt, acc);
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 100) begin
      @(posedge clk);
      #2;
      n++;
    end
    chk("drain_pending", 32'(exp_q.size()), 32'd0);
  endtask

  // monitor / scoreboard
  always @(negedge clk) begin
    if (reset) begin
      busy_run = 0;
    end else if (done) begin
      if (exp_q.size() == 0) begin
        chk("spurious_done", 32'(done), 32'd0);
      end else begin
        mon_e = exp_q.pop_front();
        chk("done_cycle", 32'(cyc), mon_e[127:96]);
        chk("busy_cycles", 32'(busy_run), {24'd0, mon_e[135:128]});
        chk("ready_in_done", 32'(in_ready), 32'd1);
        chk("hi", hi, mon_e[95:64]);
        chk("lo", lo, mon_e[63:32]);
        if (mon_e[136]) chk("mul_result", result, mon_e[31:0]);
      end
      busy_run = 0;
    end else if (busy) begin
      busy_run++;
    end else begin
      busy_run = 0;
    end
  end

  initial begin
    int a1, a2, h1, h2;
    logic [3:0] op;

    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("reset_hi", hi, 32'd0);
    chk("reset_lo", lo, 32'd0);
    chk("reset_done", 32'(done), 32'd0);
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_result", result, 32'd0);
    chk("reset_ready", 32'(in_ready), 32'd1);

    issue(OP_MULT, 32'hFFFF_FFFF, 32'd2, 0, a1, h1);
    wait_drain();
    chk("mult_hi", hi, 32'hFFFF_FFFF);
    chk("mult_lo", lo, 32'hFFFF_FFFE);

    issue(OP_DIV, 32'hFFFF_FFF9, 32'd2, 0, a1, h1);
    wait_drain();
    chk("div_lo", lo, 32'hFFFF_FFFD);
    chk("div_hi", hi, 32'hFFFF_FFFF);
    issue(OP_DIVU, 32'd7, 32'd0, 0, a1, h1);
    wait_drain();
    chk("divu_zero_lo", lo, 32'hFFFF_FFFD);
    chk("divu_zero_hi", hi, 32'hFFFF_FFFF);

    issue(OP_MTLO, 32'hFFFF_FFFF, 32'd0, 0, a1, h1);
    issue(OP_MTHI, 32'd0, 32'd0, 0, a1, h1);
    issue(OP_MADDU, 32'd1, 32'd1, 0, a1, h1);
    wait_drain();
    chk("maddu_hi", hi, 32'd1);
    chk("maddu_lo", lo, 32'd0);
    issue(OP_MSUB, 32'd1, 32'd1, 0, a1, h1);
    wait_drain();
    chk("msub_hi", hi, 32'd0);
    chk("msub_lo", lo, 32'hFFFF_FFFF);

    issue(OP_MUL, 32'h0001_0000, 32'h0001_0001, 0, a1, h1);
    wait_drain();
    chk("mul_result_const", result, 32'h0001_0000);
    chk("mul_keeps_hi", hi, 32'd0);
    chk("mul_keeps_lo", lo, 32'hFFFF_FFFF);

    issue(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 0, a1, h1);
    wait_drain();
    chk("div_ovf_lo", lo, 32'h8000_0000);
    chk("div_ovf_hi", hi, 32'd0);

    // back-to-back: second op waits out the multiply and is taken in its done cycle
    issue(OP_MULT, rnd32(), rnd32(), 0, a1, h1);
    issue(OP_MTHI, rnd32(), 32'd0, 0, a2, h2);
    chk("b2b_held_cycles", 32'(h2), 32'(MUL_CYCLES));
    chk("b2b_accept_cycle", 32'(a2), 32'(a1 + MUL_CYCLES + 1));
    wait_drain();

    // flush in cycle 10 of a divide
    issue(OP_DIV, 32'h1234_5678, 32'd3, 1, a1, h1);
    while (cyc < a1 + 9) begin
      @(posedge clk);
      #1;
    end
    flush = 1'b1;
    @(posedge clk);
    #1 flush = 1'b0;
    @(negedge clk);
    chk("flush_busy", 32'(busy), 32'd0);
    repeat (29) @(negedge clk);
    chk("flush_hi", hi, m_hi);
    chk("flush_lo", lo, m_lo);
    @(negedge clk);
    in_valid = 1'b1;
    in_op = OP_MTHI;
    in_vs = ~m_hi;
    flush = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    flush = 1'b0;
    repeat (2) @(negedge clk);
    chk("flush_mthi_hi", hi, m_hi);

    // random ops, including NONE and unused codes
    for (int i = 0; i < 80; i++) begin
      op = 4'($urandom_range(0, 15));
      issue(op, rnd32(), rnd32(), 0, a1, h1);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
    wait_drain();

    // reset in cycle 2 of a multiply
    issue(OP_MTHI, 32'hA5A5_A5A5, 32'd0, 0, a1, h1);
    wait_drain();
    issue(OP_MULT, 32'h0000_0007, 32'h0000_0009, 1, a1, h1);
    @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    m_hi = 32'd0;
    m_lo = 32'd0;
    @(negedge clk);
    chk("midreset_busy", 32'(busy), 32'd0);
    chk("midreset_done", 32'(done), 32'd0);
    chk("midreset_hi", hi, 32'd0);
    chk("midreset_lo", lo, 32'd0);
    repeat (6) @(negedge clk);
    chk("midreset_pending", 32'(exp_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
